// File: rtl/multiplier_control_pkg.sv
`default_nettype none
// ============================================================================
// Module : mult_ctrl_pkg
// Brief  : State encoding, default width and next-state rule for the
//          shift-add multiplier sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package mult_ctrl_pkg;

   localparam int MULT_N_BITS_DEFAULT = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLR   = 3'd1,
      ADD   = 3'd2,
      SHIFT = 3'd3,
      HOLD  = 3'd4
   } mult_state_t;

   // HOLD waits for Run to drop so a held Run never restarts the sequence.
   function automatic mult_state_t mult_next_state(input mult_state_t state,
                                                   input logic        run,
                                                   input logic        last);
      mult_state_t nxt;
      nxt = state;
      case (state)
         IDLE:    if (run) nxt = CLR;
         CLR:     nxt = ADD;
         ADD:     nxt = SHIFT;
         SHIFT:   nxt = last ? HOLD : ADD;
         HOLD:    if (!run) nxt = IDLE;
         default: nxt = IDLE;
      endcase
      return nxt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/multiplier_control_if.sv
`default_nettype none
// ============================================================================
// Module : multiplier_control_if
// Brief  : Request/strobe bundle between the multiplier datapath and its
//          sequencer. master = datapath side, slave = sequencer.
// Rev    : 1.0  initial release
// ============================================================================
interface multiplier_control_if;

   logic Run;
   logic ClearA_LoadB;
   logic M;
   logic ClearA;
   logic LoadB;
   logic Add;
   logic Sub;
   logic Shift;
   logic Busy;
   logic Done;

   modport master (
      output Run, ClearA_LoadB, M,
      input  ClearA, LoadB, Add, Sub, Shift, Busy, Done
   );

   modport slave (
      input  Run, ClearA_LoadB, M,
      output ClearA, LoadB, Add, Sub, Shift, Busy, Done
   );

endinterface
`default_nettype wire

// File: rtl/multiplier_control_iter_counter.sv
`default_nettype none
// ============================================================================
// Module : mult_iter_counter
// Brief  : Multiplier-bit iteration counter; saturates at N_BITS-1 and only
//          returns to zero on clr or Reset.
// Rev    : 1.0  initial release
// ============================================================================
module mult_iter_counter
   import mult_ctrl_pkg::*;
#(
   parameter int N_BITS = MULT_N_BITS_DEFAULT,
   parameter int CNT_W  = 3
) (
   input  wire logic             Clk,
   input  wire logic             Reset,
   input  wire logic             clr,
   input  wire logic             inc,
   output logic      [CNT_W-1:0] count,
   output logic                  last
);

   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N_BITS - 1);

   always_ff @(posedge Clk) begin
      if (Reset || clr) begin
         count <= '0;
      end else if (inc && !last) begin
         count <= count + CNT_W'(1);
      end
   end

   assign last = (count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/multiplier_control.sv
`default_nettype none
// ============================================================================
// Module : multiplier_control
// Brief  : Sequencer for the 8-bit signed shift-add multiplier. Optional
//          macro MULT_RUN_SYNC_EN adds a 2-flop synchronizer on Run.
// Rev    : 1.0  initial release
// ============================================================================
module multiplier_control
   import mult_ctrl_pkg::*;
#(
   parameter int N_BITS = MULT_N_BITS_DEFAULT
) (
   input wire logic             Clk,
   input wire logic             Reset,
   multiplier_control_if.slave  bus
);

   localparam int               CNT_W  = (N_BITS > 1) ? $clog2(N_BITS) : 1;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N_BITS - 1);

   logic             w_run;
   logic [CNT_W-1:0] w_count;
   logic             w_last;
   mult_state_t      r_state;
   mult_state_t      w_next;
   logic             r_idle;
   logic             r_clear_a;
   logic             r_add_slot;
   logic             r_shift;
   logic             r_busy;
   logic             r_done;

`ifdef MULT_RUN_SYNC_EN
   logic r_run_s1;
   logic r_run_s2;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_run_s1 <= 1'b0;
         r_run_s2 <= 1'b0;
      end else begin
         r_run_s1 <= bus.Run;
         r_run_s2 <= r_run_s1;
      end
   end

   assign w_run = r_run_s2;
`else
   assign w_run = bus.Run;
`endif

   assign w_next = mult_next_state(r_state, w_run, w_last);

   mult_iter_counter #(
      .N_BITS (N_BITS),
      .CNT_W  (CNT_W)
   ) u_iter_counter (
      .Clk   (Clk),
      .Reset (Reset),
      .clr   ((r_state == IDLE) && w_run),
      .inc   (r_state == SHIFT),
      .count (w_count),
      .last  (w_last)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state    <= IDLE;
         r_idle     <= 1'b1;
         r_clear_a  <= 1'b0;
         r_add_slot <= 1'b0;
         r_shift    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_idle     <= (w_next == IDLE);
         r_clear_a  <= (w_next == CLR);
         r_add_slot <= (w_next == ADD);
         r_shift    <= (w_next == SHIFT);
         r_busy     <= (w_next == CLR) || (w_next == ADD) || (w_next == SHIFT);
         r_done     <= (w_next == HOLD) && (r_state != HOLD);
      end
   end

   // The last slot subtracts: the multiplier MSB carries negative weight.
   logic w_idle_req;
   logic w_last_slot;

   assign w_idle_req  = r_idle && bus.ClearA_LoadB && !w_run;
   assign w_last_slot = (w_count == C_LAST);

   assign bus.ClearA = r_clear_a || w_idle_req;
   assign bus.LoadB  = w_idle_req;
   assign bus.Add    = r_add_slot && bus.M && !w_last_slot;
   assign bus.Sub    = r_add_slot && bus.M && w_last_slot;
   assign bus.Shift  = r_shift;
   assign bus.Busy   = r_busy;
   assign bus.Done   = r_done;

endmodule
`default_nettype wire
